// File: rtl/pic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pic_pkg
// Description : Shared types and constants for the pic_ctrl interrupt
//               controller (FSM states, register map, reset values).
// Revision    : 1.0 - initial release
// ============================================================================
package pic_pkg;

    // Request handshake states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } pic_state_t;

    // Register map
    localparam logic [1:0] ADDR_MASK = 2'd0;
    localparam logic [1:0] ADDR_TRIG = 2'd1;
    localparam logic [1:0] ADDR_PEND = 2'd2;
    localparam logic [1:0] ADDR_ISR  = 2'd3;

    // Reset values, sliced to N_IRQ by the user (N_IRQ <= 16)
    localparam logic [15:0] MASK_RST = 16'hFFFF;  // every line masked
    localparam logic [15:0] TRIG_RST = 16'hFFFF;  // every line edge-triggered

endpackage : pic_pkg
`default_nettype wire

// File: rtl/pic_if.sv
`default_nettype none
// ============================================================================
// Module      : pic_if
// Description : Core-side bus of pic_ctrl: interrupt request/acknowledge,
//               end-of-interrupt and the configuration register port.
//               The core's "int" input is carried as int_req because "int"
//               is a reserved word in SystemVerilog.
// Revision    : 1.0 - initial release
// ============================================================================
interface pic_if #(
    parameter int N_IRQ = 8,
    parameter int NUM_W = $clog2(N_IRQ)
);
    logic             int_req;
    logic [NUM_W-1:0] int_num;
    logic             int_ack;
    logic             eoi;
    logic [NUM_W-1:0] eoi_num;
    logic             cfg_we;
    logic [1:0]       cfg_addr;
    logic [N_IRQ-1:0] cfg_wdata;
    logic [N_IRQ-1:0] cfg_rdata;

    // Core / configuration agent side
    modport master (
        input  int_req, int_num, cfg_rdata,
        output int_ack, eoi, eoi_num, cfg_we, cfg_addr, cfg_wdata
    );

    // Interrupt controller side
    modport slave (
        output int_req, int_num, cfg_rdata,
        input  int_ack, eoi, eoi_num, cfg_we, cfg_addr, cfg_wdata
    );
endinterface : pic_if
`default_nettype wire

// File: rtl/pic_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : pic_prio_enc
// Description : Combinational priority encoder; returns the lowest set index
//               of a vector and a flag telling whether any bit is set.
// Revision    : 1.0 - initial release
// ============================================================================
module pic_prio_enc #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         valid
);

    // Scan from the top so the lowest set index is the last one written
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = W'(i);
        end
    end

    assign valid = |vec;

endmodule : pic_prio_enc
`default_nettype wire

// File: rtl/pic_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pic_ctrl
// Description : Sequential interrupt controller. Synchronises external
//               requests, latches pending events (edge or level per line),
//               masks them and arbitrates by fixed priority (line 0 highest)
//               against the in-service register, then runs a request /
//               acknowledge handshake with the core and accepts EOI.
// Revision    : 1.0 - initial release
// ============================================================================
module pic_ctrl
    import pic_pkg::*;
#(
    parameter int N_IRQ       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int NUM_W       = $clog2(N_IRQ)
) (
    input  wire logic             clk,
    input  wire logic             rst,       // asynchronous, active-low
    input  wire logic [N_IRQ-1:0] intReq,
    input  wire logic             en_inter,
    pic_if.slave                  bus
);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][N_IRQ-1:0] r_sync;
    logic [N_IRQ-1:0]                  r_hist;
    logic [N_IRQ-1:0]                  r_mask;
    logic [N_IRQ-1:0]                  r_trig;
    logic [N_IRQ-1:0]                  r_pend;
    logic [N_IRQ-1:0]                  r_isr;
    pic_state_t                        r_state;
    logic [NUM_W-1:0]                  r_num;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic [N_IRQ-1:0] w_synced;
    logic [N_IRQ-1:0] w_rise;
    logic [NUM_W-1:0] w_isr_lo;
    logic             w_isr_any;
    logic [N_IRQ-1:0] w_below;
    logic [N_IRQ-1:0] w_elig;
    logic [NUM_W-1:0] w_win;
    logic             w_win_any;
    logic [N_IRQ-1:0] w_num_oh;
    logic [N_IRQ-1:0] w_eoi_oh;
    logic [N_IRQ-1:0] w_pend_w1c;
    logic [N_IRQ-1:0] w_pend_nxt;
    logic [N_IRQ-1:0] w_isr_nxt;
    logic             w_mask_cur;
    logic             w_take;
    pic_state_t       w_state_nxt;

    assign w_synced = r_sync[SYNC_STAGES-1];
    assign w_rise   = w_synced & ~r_hist;

    // Lowest in-service line bounds which lines may nest
    pic_prio_enc #(.N(N_IRQ), .W(NUM_W)) u_isr_enc (
        .vec   (r_isr),
        .idx   (w_isr_lo),
        .valid (w_isr_any)
    );

    // Only lines strictly above the current in-service priority may request
    always_comb begin
        w_below = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            w_below[i] = !w_isr_any || (NUM_W'(i) < w_isr_lo);
        end
    end

    assign w_elig = r_pend & ~r_mask & ~r_isr & w_below;

    pic_prio_enc #(.N(N_IRQ), .W(NUM_W)) u_win_enc (
        .vec   (w_elig),
        .idx   (w_win),
        .valid (w_win_any)
    );

    // One-hot decodes; eoi_num values beyond N_IRQ simply match nothing
    always_comb begin
        w_num_oh = '0;
        w_eoi_oh = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            w_num_oh[i] = (r_num == NUM_W'(i));
            w_eoi_oh[i] = bus.eoi && (bus.eoi_num == NUM_W'(i));
        end
    end

    assign w_mask_cur = |(r_mask & w_num_oh);
    assign w_pend_w1c = (bus.cfg_we && bus.cfg_addr == ADDR_PEND) ? (bus.cfg_wdata & r_trig) : '0;

    // FSM state register; the winner is frozen on entry to REQ
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_num   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_state_nxt == REQ) r_num <= w_win;
        end
    end

    // FSM next state: ack has priority over withdrawal
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (en_inter && w_win_any) w_state_nxt = REQ;
            REQ: begin
                if (bus.int_ack)                 w_state_nxt = IDLE;
                else if (!en_inter || w_mask_cur) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs and register read mux
    always_comb begin
        bus.int_req = (r_state == REQ);
        bus.int_num = r_num;
        w_take      = (r_state == REQ) && bus.int_ack;
        case (bus.cfg_addr)
            ADDR_MASK: bus.cfg_rdata = r_mask;
            ADDR_TRIG: bus.cfg_rdata = r_trig;
            ADDR_PEND: bus.cfg_rdata = r_pend;
            default:   bus.cfg_rdata = r_isr;
        endcase
    end

    // Pending next value: level lines follow the input, edge lines latch;
    // a fresh edge beats both the ack clear and a W1C write
    always_comb begin
        w_pend_nxt = r_pend;
        for (int i = 0; i < N_IRQ; i++) begin
            if (!r_trig[i]) begin
                w_pend_nxt[i] = w_synced[i];
            end else begin
                if (w_take && w_num_oh[i]) w_pend_nxt[i] = 1'b0;
                if (w_pend_w1c[i])         w_pend_nxt[i] = 1'b0;
                if (w_rise[i])             w_pend_nxt[i] = 1'b1;
            end
        end
    end

    // In-service next value: EOI clears first so a same-line ack wins
    assign w_isr_nxt = (r_isr & ~w_eoi_oh) | (w_take ? w_num_oh : '0);

    // Input synchroniser chain and edge-history flop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
            r_hist <= '0;
        end else begin
            r_sync[0] <= intReq;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
            r_hist <= w_synced;
        end
    end

    // Configuration registers and interrupt status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mask <= MASK_RST[N_IRQ-1:0];
            r_trig <= TRIG_RST[N_IRQ-1:0];
            r_pend <= '0;
            r_isr  <= '0;
        end else begin
            if (bus.cfg_we && bus.cfg_addr == ADDR_MASK) r_mask <= bus.cfg_wdata;
            if (bus.cfg_we && bus.cfg_addr == ADDR_TRIG) r_trig <= bus.cfg_wdata;
            r_pend <= w_pend_nxt;
            r_isr  <= w_isr_nxt;
        end
    end

endmodule : pic_ctrl
`default_nettype wire

// File: tb/tb_pic_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pic_ctrl
// Description : Self-checking bench for pic_ctrl: directed scenarios plus a
//               randomized phase, checked by a scoreboard fed from a
//               behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pic_ctrl;
    import pic_pkg::*;

    localparam int N  = 8;
    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] intReq;
    logic         en_inter;

    pic_if #(.N_IRQ(N)) bus ();

    pic_ctrl #(.N_IRQ(N), .SYNC_STAGES(SS)) dut (
        .clk      (clk),
        .rst      (rst),
        .intReq   (intReq),
        .en_inter (en_inter),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: pending/in-service as plain bit sets, the input
    // delay as a list of past samples, the core request as busy/number.
    // ------------------------------------------------------------------
    logic [N-1:0] m_mask, m_trig, m_pend, m_isr;
    logic [N-1:0] m_seen [0:SS];   // m_seen[0] = most recent intReq sample
    bit           m_busy;
    int           m_num;
    int           exp_q[$];

    function automatic logic [N-1:0] model_reg(input logic [1:0] a);
        case (a)
            2'd0:    return m_mask;
            2'd1:    return m_trig;
            2'd2:    return m_pend;
            default: return m_isr;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin : model
        logic [N-1:0] syn, prv, npend, nisr;
        int lo, win;
        if (!rst) begin
            m_mask = '1; m_trig = '1; m_pend = '0; m_isr = '0;
            for (int k = 0; k <= SS; k++) m_seen[k] = '0;
            m_busy = 0; m_num = 0;
            exp_q.delete();
        end else begin
            syn = m_seen[SS-1];
            prv = m_seen[SS];
            lo = N;
            for (int i = N - 1; i >= 0; i--) if (m_isr[i]) lo = i;
            win = -1;
            for (int i = lo - 1; i >= 0; i--)
                if (m_pend[i] && !m_mask[i] && !m_isr[i]) win = i;
            npend = m_pend;
            nisr  = m_isr;
            if (bus.eoi && int'(bus.eoi_num) < N) nisr[bus.eoi_num] = 1'b0;
            if (!m_busy) begin
                if (en_inter && win >= 0) begin
                    m_busy = 1; m_num = win;
                    exp_q.push_back(win);
                end
            end else if (bus.int_ack) begin
                nisr[m_num] = 1'b1;
                if (m_trig[m_num]) npend[m_num] = 1'b0;
                m_busy = 0;
            end else if (!en_inter || m_mask[m_num]) begin
                m_busy = 0;
            end
            if (bus.cfg_we && bus.cfg_addr == 2'd2)
                for (int i = 0; i < N; i++) if (m_trig[i] && bus.cfg_wdata[i]) npend[i] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!m_trig[i])                npend[i] = syn[i];
                else if (syn[i] && !prv[i])    npend[i] = 1'b1;
            end
            if (bus.cfg_we && bus.cfg_addr == 2'd0) m_mask = bus.cfg_wdata;
            if (bus.cfg_we && bus.cfg_addr == 2'd1) m_trig = bus.cfg_wdata;
            m_pend = npend;
            m_isr  = nisr;
            for (int k = SS; k > 0; k--) m_seen[k] = m_seen[k-1];
            m_seen[0] = intReq;
        end
    end

    // ------------------------------------------------------------------
    // Monitor: compares DUT outputs against the model away from the edge
    // and pops the scoreboard whenever a new request is presented.
    // ------------------------------------------------------------------
    logic prev_int = 1'b0;
    always @(negedge clk) begin
        check("int_level", 32'(bus.int_req), 32'(m_busy));
        if (bus.int_req) check("int_num", 32'(bus.int_num), 32'(m_num));
        check("cfg_rdata", 32'(bus.cfg_rdata), 32'(model_reg(bus.cfg_addr)));
        if (bus.int_req && !prev_int) begin
            if (exp_q.size() == 0) check("req_unexpected", 32'(bus.int_num), 32'hFFFF_FFFF);
            else                   check("req_scoreboard", 32'(bus.int_num), 32'(exp_q.pop_front()));
        end
        prev_int = bus.int_req;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [N-1:0] d);
        bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = d;
        tick(1);
        bus.cfg_we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input string name, input logic [N-1:0] exp);
        bus.cfg_addr = a;
        #1;
        check(name, 32'(bus.cfg_rdata), 32'(exp));
    endtask

    task automatic ack();
        bus.int_ack = 1'b1;
        tick(1);
        bus.int_ack = 1'b0;
    endtask

    task automatic do_eoi(input int n);
        bus.eoi = 1'b1; bus.eoi_num = 3'(n);
        tick(1);
        bus.eoi = 1'b0;
    endtask

    task automatic wait_int(input int budget, input string name, input int exp_num);
        int t = 0;
        while (!bus.int_req && t < budget) begin
            tick(1);
            t++;
        end
        if (!bus.int_req) check({name, "_timeout"}, 32'd0, 32'd1);
        else              check(name, 32'(bus.int_num), 32'(exp_num));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b1; intReq = '0; en_inter = 1'b1;
        bus.int_ack = 0; bus.eoi = 0; bus.eoi_num = '0;
        bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
        #2 rst = 1'b0;
        tick(3);
        @(negedge clk) rst = 1'b1;
        tick(1);

        // Reset state
        check("rst_int", 32'(bus.int_req), 32'd0);
        check("rst_num", 32'(bus.int_num), 32'd0);
        rd(ADDR_MASK, "rst_mask", 8'hFF);
        rd(ADDR_TRIG, "rst_trig", 8'hFF);
        rd(ADDR_PEND, "rst_pend", 8'h00);
        rd(ADDR_ISR,  "rst_isr",  8'h00);

        // 1: latency and ack
        cfg_write(ADDR_MASK, 8'hFE);
        tick(1);
        intReq[0] = 1'b1;
        tick(1); check("t1_lat_e1", 32'(bus.int_req), 32'd0);
        tick(1); check("t1_lat_e2", 32'(bus.int_req), 32'd0);
        tick(1); check("t1_lat_e3", 32'(bus.int_req), 32'd0);
        intReq[0] = 1'b0;
        tick(1); check("t1_lat_e4", 32'(bus.int_req), 32'd1);
        check("t1_num", 32'(bus.int_num), 32'd0);
        ack();
        check("t1_int_after_ack", 32'(bus.int_req), 32'd0);
        rd(ADDR_ISR,  "t1_isr",  8'h01);
        rd(ADDR_PEND, "t1_pend", 8'h00);
        cfg_write(ADDR_ISR, 8'hFF);
        rd(ADDR_ISR, "t1_isr_ro", 8'h01);
        do_eoi(0);
        rd(ADDR_ISR, "t1_isr_eoi", 8'h00);

        // 2: simultaneous arrivals, blocked lower priority until EOI
        cfg_write(ADDR_MASK, 8'h00);
        intReq = 8'h24;
        wait_int(10, "t2_first", 2);
        ack();
        rd(ADDR_ISR, "t2_isr", 8'h04);
        tick(4);
        check("t2_blocked", 32'(bus.int_req), 32'd0);
        do_eoi(2);
        wait_int(2, "t2_second", 5);
        ack();
        do_eoi(5);
        intReq = '0;
        tick(3);

        // 3: nesting
        intReq[6] = 1'b1;
        wait_int(10, "t3_line6", 6);
        ack();
        intReq[1] = 1'b1;
        wait_int(10, "t3_nested", 1);
        ack();
        rd(ADDR_ISR, "t3_isr_nest", 8'h42);
        do_eoi(1);
        do_eoi(6);
        rd(ADDR_ISR, "t3_isr_clear", 8'h00);
        intReq = '0;
        tick(3);

        // 4: withdrawal on en_inter drop
        intReq[3] = 1'b1;
        wait_int(10, "t4_req", 3);
        en_inter = 1'b0;
        tick(1);
        check("t4_withdraw", 32'(bus.int_req), 32'd0);
        rd(ADDR_PEND, "t4_pend", 8'h08);
        en_inter = 1'b1;
        wait_int(5, "t4_rereq", 3);
        ack();
        do_eoi(3);
        intReq = '0;
        tick(3);

        // 5: level mode
        cfg_write(ADDR_TRIG, 8'hFE);
        intReq[0] = 1'b1;
        wait_int(10, "t5_req", 0);
        ack();
        check("t5_int_after_ack", 32'(bus.int_req), 32'd0);
        rd(ADDR_PEND, "t5_pend_held", 8'h01);
        do_eoi(0);
        wait_int(3, "t5_rereq", 0);
        ack();
        intReq[0] = 1'b0;
        tick(4);
        rd(ADDR_PEND, "t5_pend_drop", 8'h00);
        do_eoi(0);
        cfg_write(ADDR_TRIG, 8'hFF);
        tick(2);

        // 6: reset mid-handshake
        intReq[4] = 1'b1;
        wait_int(10, "t6_req", 4);
        #3 rst = 1'b0;
        #1 check("t6_int_rst", 32'(bus.int_req), 32'd0);
        rd(ADDR_MASK, "t6_mask", 8'hFF);
        rd(ADDR_PEND, "t6_pend", 8'h00);
        rd(ADDR_ISR,  "t6_isr",  8'h00);
        @(negedge clk) rst = 1'b1;
        tick(1);
        ack();
        rd(ADDR_ISR, "t6_ack_ignored", 8'h00);
        check("t6_int_idle", 32'(bus.int_req), 32'd0);
        intReq = '0;
        tick(3);

        // Randomized phase
        cfg_write(ADDR_MASK, 8'h00);
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 7) == 0) intReq[i] = ~intReq[i];
            en_inter    = ($urandom_range(0, 15) != 0);
            bus.int_ack = bus.int_req ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 63) == 0);
            bus.eoi     = ($urandom_range(0, 7) == 0);
            if (m_isr != 0 && $urandom_range(0, 9) < 7) begin
                for (int i = N - 1; i >= 0; i--) if (m_isr[i]) bus.eoi_num = 3'(i);
            end else begin
                bus.eoi_num = 3'($urandom_range(0, N - 1));
            end
            bus.cfg_we   = ($urandom_range(0, 15) == 0);
            bus.cfg_addr = 2'($urandom_range(0, 3));
            if (bus.cfg_addr == ADDR_MASK) bus.cfg_wdata = N'($urandom & $urandom & $urandom);
            else                           bus.cfg_wdata = N'($urandom);
            tick(1);
        end
        bus.int_ack = 0; bus.eoi = 0; bus.cfg_we = 0; en_inter = 1'b1;
        tick(5);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pic_ctrl
`default_nettype wire

// File: doc/pic_ctrl.md
Name: pic_ctrl

Overview:
- Sequential interrupt controller between the external `intReq[7:0]` lines and the RISCV core's `int`/`int_num` inputs. Replaces the purely combinational encoder.
- Functions: synchronises requests, latches pending events (edge or level per line), masks, and arbitrates by fixed priority (line 0 highest) against an in-service register.
- Runs a request/acknowledge handshake with the core and accepts end-of-interrupt (EOI) so handlers nest only for higher-priority lines.
- Configured through a small register port.

Parameters:
- N_IRQ, 8, number of request lines (2..16).
- SYNC_STAGES, 2, synchroniser depth on `intReq`.
- NUM_W, $clog2(N_IRQ), width of interrupt numbers.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- intReq  in  N_IRQ  asynchronous external requests.
- en_inter  in  1  global interrupt enable from the core.
- int  out  1  interrupt request to the core.
- int_num  out  NUM_W  line number being requested; valid while `int`=1.
- int_ack  in  1  one-cycle pulse: the core has taken the trap for `int_num`.
- eoi  in  1  one-cycle pulse: the handler for `eoi_num` has finished.
- eoi_num  in  NUM_W  line being retired.
- cfg_we  in  1  register write strobe.
- cfg_addr  in  2  register select: 0=MASK, 1=TRIG, 2=PEND, 3=ISR.
- cfg_wdata  in  N_IRQ  write data.
- cfg_rdata  out  N_IRQ  combinational read of the selected register.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE; `int`=0, `int_num`=0.
  - MASK = all 1s (all lines masked). TRIG = all 1s (edge mode).
  - PEND = 0, ISR = 0; synchroniser and edge flops = 0.
  - Reset mid-handshake abandons the request with no side effects.
- Input path: SYNC_STAGES flops, then one history flop per line.
  - Edge line (TRIG=1): a rising edge of the synchronised signal sets PEND.
  - Level line (TRIG=0): PEND equals the synchronised level every cycle.
- Eligible set = PEND & ~MASK & ~ISR, restricted to indices below the lowest set ISR bit (all indices when ISR=0).
  - Winner = lowest eligible index.
- FSM IDLE:
  - If `en_inter`=1 and the eligible set is non-empty, go to REQ on the next edge.
  - On that edge, register `int`=1 and `int_num`=winner.
- FSM REQ:
  - `int_num` is frozen; a later higher-priority arrival does not change it.
  - If `int_ack`=1: set ISR[int_num]; clear PEND[int_num] if edge mode; `int`=0; go to IDLE.
  - Else if `en_inter`=0, or MASK[int_num] has become 1: withdraw, `int`=0, go to IDLE. No state change.
  - After any exit, re-arbitration occurs no earlier than the following cycle, so `int` is low for at least one cycle between requests.
- `int_ack` in IDLE is ignored.
- EOI: `eoi`=1 clears ISR[eoi_num]. EOI for a line not in service is ignored. EOI is legal in any state.
- Latency: `intReq` high sampled at edge 1 → `int`=1 after edge SYNC_STAGES+2 (edge 4 with defaults), provided the line is unmasked and nothing is in service.
- Simultaneous events:
  - A new edge on line k in the same cycle `int_ack` clears PEND[k]: PEND[k] stays 1.
  - `int_ack` and `eoi` in the same cycle: both apply, set and clear independently. The same line in both: ISR ends set.
  - A cfg write to PEND in the same cycle as a new edge: the edge wins.
- Level mode: `int_ack` does not clear PEND. ISR blocks re-request until EOI. A still-high line then re-requests.
- Registers:
  - MASK and TRIG are read/write.
  - PEND reads; writes are write-1-to-clear, edge lines only.
  - ISR is read-only; writes are ignored.
  - Changing TRIG from 1 to 0 leaves PEND governed by level from the next cycle.
- Indices ≥ N_IRQ in `eoi_num` are ignored.

Decomposition:
- pic_pkg:
  - state enum {IDLE, REQ};
  - register address constants ADDR_MASK=0, ADDR_TRIG=1, ADDR_PEND=2, ADDR_ISR=3;
  - reset constants for MASK/TRIG.
- Sub-module pic_prio_enc (combinational): given an N_IRQ vector, returns the lowest set index plus a valid flag. Instantiated twice: once for the eligible winner, once for the lowest ISR bit.
- Synchroniser and edge logic stay inline.

Test Plan:
1. After reset, write MASK=0xFE; pulse intReq[0] for 3 cycles → `int`=1, `int_num`=0 at edge 4. Pulse `int_ack` → ISR=0x01, PEND=0x00, `int`=0 next cycle.
2. With MASK=0x00, raise intReq[5] and intReq[2] in the same cycle → request for `int_num`=2. Ack → ISR=0x04. `int_num`=5 is not requested until `eoi` with `eoi_num`=2; it then follows within 2 cycles.
3. With line 6 in service, raise intReq[1] → nested request with `int_num`=1. Ack → ISR=0x42. EOI 1, then EOI 6 → ISR=0x00.
4. While `int`=1 for line 3, drop `en_inter` → `int`=0 next cycle, PEND[3] still 1. Restore `en_inter` → re-request for line 3.
5. Set TRIG=0xFE and hold intReq[0] high. Ack, then EOI → `int` reasserts for line 0. Drop intReq[0] → PEND[0]=0 after the sync latency.
6. Assert rst while in REQ → `int`=0 immediately, MASK=0xFF, PEND=0, ISR=0. `int_ack` after reset is ignored.
